// File: rtl/sound_mailbox.sv
// sound_mailbox: main/sound CPU command and response mailbox with NMI, IRQ and sound reset control
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   main_wr_l, main_rd_l, main_ctl_wr_l  main-side strobes: command write, response read, control write
//   main_din / main_dout              main write data / response latch contents
//   main_irq_l                        response pending interrupt to main CPU (active low)
//   snd_wr68k_l, snd_rd68k_l          sound-side strobes: response write, command read
//   snd_din / snd_dout                sound write data / command latch contents
//   snd_nmi_l, snd_reset              NMI pulse and reset to sound CPU
//   cmd_full, rsp_full, cmd_ovr, rsp_ovr  latch status and sticky overrun flags
module sound_mailbox #(
    parameter int DATA_W     = 8,
    parameter int NMI_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              main_wr_l,
    input  logic              main_rd_l,
    input  logic              main_ctl_wr_l,
    input  logic [DATA_W-1:0] main_din,
    output logic [DATA_W-1:0] main_dout,
    output logic              main_irq_l,
    input  logic              snd_wr68k_l,
    input  logic              snd_rd68k_l,
    input  logic [DATA_W-1:0] snd_din,
    output logic [DATA_W-1:0] snd_dout,
    output logic              snd_nmi_l,
    output logic              snd_reset,
    output logic              cmd_full,
    output logic              rsp_full,
    output logic              cmd_ovr,
    output logic              rsp_ovr
);
    logic [4:0] strb, hist, ev;
    logic [7:0] cnt;
    logic main_wr_ev, main_rd_ev, ctl_ev, snd_wr_ev, snd_rd_ev;
    assign strb = {main_wr_l, main_rd_l, main_ctl_wr_l, snd_wr68k_l, snd_rd68k_l};
    assign ev = ~strb & hist;
    assign {main_wr_ev, main_rd_ev, ctl_ev, snd_wr_ev, snd_rd_ev} = ev;
    assign snd_nmi_l = (cnt == 8'd0);
    assign main_irq_l = ~rsp_full;
    always_ff @(posedge clk) begin
        if (rst) begin
            hist      <= '1;
            snd_dout  <= '0;
            main_dout <= '0;
            cmd_full  <= 1'b0;
            rsp_full  <= 1'b0;
            cmd_ovr   <= 1'b0;
            rsp_ovr   <= 1'b0;
            cnt       <= 8'd0;
            snd_reset <= 1'b1;
        end else begin
            hist <= strb;
            if (main_wr_ev) snd_dout <= main_din;
            if (ctl_ev) snd_reset <= main_din[0];
            // snd_reset is sampled before this edge's control write takes effect
            if (snd_reset) begin
                cmd_full <= 1'b0;
                rsp_full <= 1'b0;
                cnt      <= 8'd0;
            end else begin
                if (snd_wr_ev) main_dout <= snd_din;
                // write wins over a same-cycle read
                cmd_full <= main_wr_ev | (cmd_full & ~snd_rd_ev);
                rsp_full <= snd_wr_ev | (rsp_full & ~main_rd_ev);
                if (main_wr_ev & cmd_full) cmd_ovr <= 1'b1;
                if (snd_wr_ev & rsp_full) rsp_ovr <= 1'b1;
                cnt <= main_wr_ev ? 8'(NMI_CYCLES) : (cnt != 8'd0 ? cnt - 8'd1 : 8'd0);
            end
        end
    end
endmodule

// File: tb/tb_sound_mailbox.sv
// tb_sound_mailbox: table-driven scoreboard bench for sound_mailbox
module tb_sound_mailbox;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic main_wr_l = 1'b1, main_rd_l = 1'b1, main_ctl_wr_l = 1'b1;
    logic snd_wr68k_l = 1'b1, snd_rd68k_l = 1'b1;
    logic [7:0] main_din = '0, snd_din = '0, main_dout, snd_dout;
    logic main_irq_l, snd_nmi_l, snd_reset, cmd_full, rsp_full, cmd_ovr, rsp_ovr;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sound_mailbox #(.DATA_W(8), .NMI_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .main_wr_l(main_wr_l), .main_rd_l(main_rd_l), .main_ctl_wr_l(main_ctl_wr_l),
        .main_din(main_din), .main_dout(main_dout), .main_irq_l(main_irq_l),
        .snd_wr68k_l(snd_wr68k_l), .snd_rd68k_l(snd_rd68k_l),
        .snd_din(snd_din), .snd_dout(snd_dout), .snd_nmi_l(snd_nmi_l),
        .snd_reset(snd_reset), .cmd_full(cmd_full), .rsp_full(rsp_full),
        .cmd_ovr(cmd_ovr), .rsp_ovr(rsp_ovr)
    );

    // stb = {main_wr_l, main_rd_l, main_ctl_wr_l, snd_wr68k_l, snd_rd68k_l}
    // exp = {snd_dout, main_dout, irq_l, nmi_l, snd_reset, cmd_full, rsp_full, cmd_ovr, rsp_ovr}
    typedef struct {
        logic        rst;
        logic [4:0]  stb;
        logic [7:0]  md;
        logic [7:0]  sd;
        logic [22:0] exp;
    } vec_t;

    typedef struct {
        string       nm;
        logic [22:0] e;
    } sb_t;

    sb_t sb[$];
    vec_t tbl[30];

    localparam logic [4:0] IDLE = 5'b11111, WR = 5'b01111, RD = 5'b10111, CTL = 5'b11011,
                           SWR = 5'b11101, SRD = 5'b11110;

    function automatic vec_t v(input logic r, input logic [4:0] s, input logic [7:0] md,
                               input logic [7:0] sd, input logic [7:0] sdo,
                               input logic [7:0] mdo, input logic [6:0] f);
        vec_t t;
        t.rst = r; t.stb = s; t.md = md; t.sd = sd; t.exp = {sdo, mdo, f};
        return t;
    endfunction

    task automatic step(input vec_t t, input string nm);
        sb_t e;
        logic [22:0] got;
        rst = t.rst;
        {main_wr_l, main_rd_l, main_ctl_wr_l, snd_wr68k_l, snd_rd68k_l} = t.stb;
        main_din = t.md;
        snd_din = t.sd;
        sb.push_back('{nm, t.exp});
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        got = {snd_dout, main_dout, main_irq_l, snd_nmi_l, snd_reset, cmd_full, rsp_full,
               cmd_ovr, rsp_ovr};
        n_chk++;
        if (got !== e.e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.nm, got, e.e);
        end
    endtask

    initial begin
        tbl[0]  = v(0, CTL,      8'h00, 8'h00, 8'h00, 8'h00, 7'b1100000);
        tbl[1]  = v(0, WR,       8'h5A, 8'h00, 8'h5A, 8'h00, 7'b1001000);
        tbl[2]  = v(0, WR,       8'h5A, 8'h00, 8'h5A, 8'h00, 7'b1001000);
        tbl[3]  = v(0, WR,       8'h5A, 8'h00, 8'h5A, 8'h00, 7'b1001000);
        tbl[4]  = v(0, IDLE,     8'h00, 8'h00, 8'h5A, 8'h00, 7'b1001000);
        tbl[5]  = v(0, IDLE,     8'h00, 8'h00, 8'h5A, 8'h00, 7'b1101000);
        tbl[6]  = v(0, SRD,      8'h00, 8'h00, 8'h5A, 8'h00, 7'b1100000);
        tbl[7]  = v(0, SWR,      8'h00, 8'hC3, 8'h5A, 8'hC3, 7'b0100100);
        tbl[8]  = v(0, RD,       8'h00, 8'h00, 8'h5A, 8'hC3, 7'b1100000);
        tbl[9]  = v(0, WR,       8'h11, 8'h00, 8'h11, 8'hC3, 7'b1001000);
        tbl[10] = v(0, IDLE,     8'h00, 8'h00, 8'h11, 8'hC3, 7'b1001000);
        tbl[11] = v(0, WR,       8'h22, 8'h00, 8'h22, 8'hC3, 7'b1001010);
        tbl[12] = v(0, IDLE,     8'h00, 8'h00, 8'h22, 8'hC3, 7'b1001010);
        tbl[13] = v(0, IDLE,     8'h00, 8'h00, 8'h22, 8'hC3, 7'b1001010);
        tbl[14] = v(0, IDLE,     8'h00, 8'h00, 8'h22, 8'hC3, 7'b1001010);
        tbl[15] = v(0, IDLE,     8'h00, 8'h00, 8'h22, 8'hC3, 7'b1101010);
        tbl[16] = v(0, WR & SRD, 8'h33, 8'h00, 8'h33, 8'hC3, 7'b1001010);
        tbl[17] = v(0, IDLE,     8'h00, 8'h00, 8'h33, 8'hC3, 7'b1001010);
        tbl[18] = v(0, IDLE,     8'h00, 8'h00, 8'h33, 8'hC3, 7'b1001010);
        tbl[19] = v(0, IDLE,     8'h00, 8'h00, 8'h33, 8'hC3, 7'b1001010);
        tbl[20] = v(0, IDLE,     8'h00, 8'h00, 8'h33, 8'hC3, 7'b1101010);
        tbl[21] = v(0, SRD,      8'h00, 8'h00, 8'h33, 8'hC3, 7'b1100010);
        tbl[22] = v(0, SWR,      8'h00, 8'hA1, 8'h33, 8'hA1, 7'b0100110);
        tbl[23] = v(0, IDLE,     8'h00, 8'h00, 8'h33, 8'hA1, 7'b0100110);
        tbl[24] = v(0, SWR,      8'h00, 8'hB2, 8'h33, 8'hB2, 7'b0100111);
        tbl[25] = v(0, CTL,      8'h01, 8'h00, 8'h33, 8'hB2, 7'b0110111);
        tbl[26] = v(0, SWR,      8'h00, 8'h77, 8'h33, 8'hB2, 7'b1110011);
        tbl[27] = v(0, WR,       8'h44, 8'h00, 8'h44, 8'hB2, 7'b1110011);
        tbl[28] = v(0, IDLE,     8'h00, 8'h00, 8'h44, 8'hB2, 7'b1110011);
        tbl[29] = v(0, SRD,      8'h00, 8'h00, 8'h44, 8'hB2, 7'b1110011);
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            step(v(1, IDLE, 8'h00, 8'h00, 8'h00, 8'h00, 7'b1110000), $sformatf("reset%0d", i));
        for (int i = 0; i < 30; i++)
            step(tbl[i], $sformatf("row%0d", i));
        step(v(0, CTL,  8'h00, 8'h00, 8'h44, 8'hB2, 7'b1100011), "midpulse_ctl");
        step(v(0, WR,   8'h66, 8'h00, 8'h66, 8'hB2, 7'b1001011), "midpulse_wr");
        step(v(1, IDLE, 8'h00, 8'h00, 8'h00, 8'h00, 7'b1110000), "midpulse_rst");
        step(v(1, WR,   8'h9A, 8'h00, 8'h00, 8'h00, 7'b1110000), "held_rst");
        step(v(0, WR,   8'h9A, 8'h00, 8'h9A, 8'h00, 7'b1110000), "held_first");
        step(v(0, WR & CTL, 8'h00, 8'h00, 8'h9A, 8'h00, 7'b1100000), "held_ctl");
        step(v(0, WR,   8'h00, 8'h00, 8'h9A, 8'h00, 7'b1100000), "held_noev");
        step(v(0, IDLE, 8'h00, 8'h00, 8'h9A, 8'h00, 7'b1100000), "held_rel");
        step(v(0, WR,   8'hBB, 8'h00, 8'hBB, 8'h00, 7'b1001000), "held_new");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sound_mailbox.md
Name: sound_mailbox

Overview:
- Main-CPU (68010) side counterpart of the sound CPU (6502) address decode: two 8-bit mailbox latches between the CPUs.
  - Command latch: main writes, sound reads.
  - Response latch: sound writes, main reads.
- Generates the sound-CPU NMI pulse on each new command and the main-CPU level interrupt on each new response.
- Owns the sound-CPU reset control bit.
- Consumes the sound-side active-low strobes WR68k_l / RD68k_l and the main-side sound-port strobes.

Parameters:
DATA_W, 8, mailbox data width
NMI_CYCLES, 4, length in clk cycles of the snd_nmi_l low pulse (1..255)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
main_wr_l  input  1  active-low main write strobe to command latch; level, may stay low several cycles
main_rd_l  input  1  active-low main read strobe of response latch
main_ctl_wr_l  input  1  active-low main write strobe to sound-reset control bit
main_din  input  DATA_W  main write data
main_dout  output  DATA_W  response latch contents
main_irq_l  output  1  active-low level interrupt to main CPU: response pending
snd_wr68k_l  input  1  active-low sound-CPU write strobe to response latch (WR68k_l)
snd_rd68k_l  input  1  active-low sound-CPU read strobe of command latch (RD68k_l)
snd_din  input  DATA_W  sound-CPU write data
snd_dout  output  DATA_W  command latch contents
snd_nmi_l  output  1  active-low NMI pulse to sound CPU
snd_reset  output  1  active-high reset to sound CPU
cmd_full  output  1  command written, not yet read by sound CPU
rsp_full  output  1  response written, not yet read by main CPU
cmd_ovr  output  1  sticky: main wrote while cmd_full=1
rsp_ovr  output  1  sticky: sound wrote while rsp_full=1

Behaviour:
- Reset values (rst=1 at clock edge):
  - cmd_data=0, rsp_data=0, cmd_full=0, rsp_full=0, cmd_ovr=0, rsp_ovr=0.
  - snd_nmi_l=1, NMI counter=0, snd_reset=1 (sound CPU held in reset).
  - All strobe-history registers=1.
- Strobe edge detection:
  - Each of the 5 strobes is registered.
  - An event is the cycle where the strobe is 0 and its registered value is 1; the event acts at that clock edge.
  - A strobe held low produces exactly one event.
  - After reset, a strobe already low produces an event on the first cycle after rst deasserts.
- Main write event: cmd_data<=main_din; cmd_full<=1; if cmd_full was already 1, then cmd_ovr<=1; data is overwritten, newest wins.
- Sound read event: cmd_full<=0. snd_dout = cmd_data, driven continuously from the register.
- Sound write event: rsp_data<=snd_din; rsp_full<=1; if rsp_full was already 1, then rsp_ovr<=1.
- Main read event: rsp_full<=0. main_dout = rsp_data, driven continuously.
- Simultaneous write and read events on the same latch in one cycle: the write wins. Data is updated, full=1, and ovr is set only if full was 1 before the edge.
- main_irq_l = ~rsp_full, registered; it goes low the cycle after the sound write event.
- NMI pulse generation:
  - Each main write event loads counter=NMI_CYCLES and drives snd_nmi_l=0 from the next cycle.
  - The counter decrements each cycle; snd_nmi_l returns to 1 when it reaches 0, giving exactly NMI_CYCLES low cycles.
  - A write during an active pulse reloads the counter, extending the pulse; there is no gap.
- Control write event: snd_reset<=main_din[0].
- While snd_reset=1:
  - cmd_full and rsp_full are forced to 0.
  - Sound-side events are ignored and the NMI counter is held at 0 (snd_nmi_l=1).
  - Main writes still load cmd_data but do not set cmd_full and do not fire NMI.
  - cmd_data, rsp_data and the ovr flags are retained.
- Reset mid-pulse or mid-transfer: rst overrides everything and returns all state to the reset values.
- Width: all data paths are DATA_W bits, with no sign extension. The counter is 8 bits.

Test Plan:
- rst high 3 cycles, then low: all outputs at reset values; snd_reset=1, snd_nmi_l=1, main_irq_l=1, cmd_full=0.
- Control write with main_din=0x00, then main write 0x5A with strobe held low 3 cycles: snd_dout=0x5A, cmd_full=1, exactly one NMI pulse of 4 low cycles. Sound read then gives cmd_full=0.
- Sound write 0xC3: rsp_full=1, main_irq_l=0 the next cycle. Main read: main_irq_l returns to 1, main_dout=0xC3.
- Main writes 0x11 then 0x22 with no read between, 2 cycles apart: snd_dout=0x22, cmd_ovr=1, NMI low for 6 consecutive cycles (pulse reloaded). Sound read and main write 0x33 in the same cycle: cmd_full=1, snd_dout=0x33.
- With snd_reset=1: sound write 0x77 gives rsp_full=0 and rsp_data unchanged. Main write 0x44 gives cmd_data=0x44, cmd_full=0, no NMI.
- rst asserted on the 2nd cycle of an NMI pulse: snd_nmi_l=1 the next cycle, counter=0, snd_reset=1.
